// File: rtl/sigmoid_inv_bisect_if.sv
// sigmoid_inv_bisect_if: stream interface for the inverse-sigmoid (logit) solver.
//   in_valid/in_ready/in_y     : upstream target probability y, signed Q4.28
//   out_valid/out_ready/out_x  : downstream result x, signed Q2.14
//   out_sat                    : present only when SIGINV_SAT_EN is defined
// Modports: master = stream source/sink side (drives in_*, out_ready),
//           slave  = solver side.
interface sigmoid_inv_bisect_if #(
   parameter int unsigned X_W = 17,
   parameter int unsigned Y_W = 33
);
   logic           in_valid;
   logic           in_ready;
   logic [Y_W-1:0] in_y;
   logic           out_valid;
   logic           out_ready;
   logic [X_W-1:0] out_x;
`ifdef SIGINV_SAT_EN
   logic           out_sat;

   modport master (
      output in_valid, in_y, out_ready,
      input  in_ready, out_valid, out_x, out_sat
   );
   modport slave (
      input  in_valid, in_y, out_ready,
      output in_ready, out_valid, out_x, out_sat
   );
`else
   modport master (
      output in_valid, in_y, out_ready,
      input  in_ready, out_valid, out_x
   );
   modport slave (
      input  in_valid, in_y, out_ready,
      output in_ready, out_valid, out_x
   );
`endif
endinterface

// File: rtl/sigmoid_inv_bisect.sv
// sigmoid_inv_bisect: inverse of the SONF sigmoid approximation.
//   Takes a Q4.28 probability y and finds the Q2.14 x whose forward sigmoid best
//   matches it, by 16-step MSB-first bisection against the forward polynomial
//   g(m) = 2^27 + (m<<12) - ((m*m)>>5), so results agree bit-for-bit with the
//   forward path. Inputs outside [0, 2^28] clamp to -/+65535 in one cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sigmoid_inv_bisect_if.slave (in_valid/in_ready/in_y,
//           out_valid/out_ready/out_x[, out_sat])
// Optional feature macro: SIGINV_SAT_EN adds the registered out_sat flag.
module sigmoid_inv_bisect #(
   parameter int unsigned X_W = 17,
   parameter int unsigned Y_W = 33
) (
   input logic                 clk,
   input logic                 rst_n,
   sigmoid_inv_bisect_if.slave bus
);

   if (X_W != 17 || Y_W != 33) begin : g_param_check
      $error("sigmoid_inv_bisect supports only X_W=17, Y_W=33");
   end

   localparam logic [33:0] Half = 34'd134217728;  // 0.5 in Q4.28
   localparam logic [33:0] One  = 34'd268435456;  // 1.0 in Q4.28

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e      state_q;
   logic        in_ready_q;
   logic        out_valid_q;
   logic [16:0] out_x_q;
   logic [15:0] m_q;
   logic [3:0]  bit_q;
   logic [33:0] t_q;
   logic        neg_q;
`ifdef SIGINV_SAT_EN
   logic        sat_q;
   logic        out_sat_q;
`endif

   // Input fold and range classification
   logic [33:0] y_ext;
   logic        y_lo;
   logic        y_hi;
   logic        y_neg;
   logic [33:0] t_fold;

   always_comb begin
      y_ext  = {bus.in_y[32], bus.in_y};
      y_lo   = bus.in_y[32];
      y_hi   = $signed(y_ext) > $signed(One);
      y_neg  = $signed(y_ext) < $signed(Half);
      // f(-x) = 1 - f(x): below 0.5 solve on the mirrored value
      t_fold = y_neg ? (One - y_ext) : y_ext;
   end

   // One forward-polynomial evaluation per cycle on the trial candidate
   logic [15:0] trial;
   logic [31:0] sq;
   logic [33:0] g_trial;

   always_comb begin
      trial   = m_q | (16'h1 << bit_q);
      sq      = {16'b0, trial} * {16'b0, trial};
      g_trial = Half + {6'b0, trial, 12'b0} - ({2'b0, sq} >> 5);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         m_q         <= '0;
         bit_q       <= '0;
         t_q         <= '0;
         neg_q       <= 1'b0;
`ifdef SIGINV_SAT_EN
         sat_q       <= 1'b0;
         out_sat_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!in_ready_q) begin
                  in_ready_q <= 1'b1;
               end else if (bus.in_valid) begin
                  in_ready_q <= 1'b0;
                  neg_q      <= y_neg;
                  t_q        <= t_fold;
                  bit_q      <= 4'd15;
`ifdef SIGINV_SAT_EN
                  sat_q      <= y_lo | y_hi;
`endif
                  if (y_lo || y_hi) begin
                     // Clamp: full-scale magnitude, sign already in y_neg
                     m_q     <= 16'hFFFF;
                     state_q <= StDone;
                  end else begin
                     m_q     <= '0;
                     state_q <= StCalc;
                  end
               end
            end
            StCalc: begin
               if (g_trial <= t_q) begin
                  m_q <= trial;
               end
               if (bit_q == 4'd0) begin
                  state_q <= StDone;
               end else begin
                  bit_q <= bit_q - 4'd1;
               end
            end
            StDone: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  out_x_q     <= neg_q ? (17'd0 - {1'b0, m_q}) : {1'b0, m_q};
`ifdef SIGINV_SAT_EN
                  out_sat_q   <= sat_q;
`endif
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_x     = out_x_q;
`ifdef SIGINV_SAT_EN
   assign bus.out_sat   = out_sat_q;
`endif

endmodule

// File: tb/tb_sigmoid_inv_bisect.sv
// tb_sigmoid_inv_bisect: scoreboard bench for sigmoid_inv_bisect.
//   Driver pushes the model's expected result on every accepted input; a
//   monitor pops and compares whenever out_valid rises, and checks hold and
//   latency. Directed cases, a reset-in-flight case, then a random sweep.
module tb_sigmoid_inv_bisect;

   logic clk;
   logic rst_n;

   sigmoid_inv_bisect_if bus ();

   sigmoid_inv_bisect dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int x;
      bit sat;
      int lat;
      int accept;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   sent = 0;
   int   results = 0;
   int   cyc = 0;
   int   ready_mode = 1;  // 0 random, 1 always ready, 2 stall

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference model straight from the arithmetic definition
   function automatic longint g_ref(input longint m);
      return 64'd134217728 + m * 4096 - (m * m) / 32;
   endfunction

   function automatic int ref_x(input longint y);
      longint t, lo, hi, mid;
      bit     neg;
      if (y < 0) return -65535;
      if (y > 268435456) return 65535;
      neg = (y < 134217728);
      t   = neg ? 268435456 - y : y;
      lo  = 0;
      hi  = 65535;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (g_ref(mid) <= t) lo = mid;
         else hi = mid - 1;
      end
      return neg ? -int'(lo) : int'(lo);
   endfunction

   task automatic send(input longint y);
      int  budget;
      bit  sat;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_y     = 33'(y);
      budget = 0;
      while (!bus.in_ready && budget < 1000) begin
         @(negedge clk);
         budget++;
      end
      if (!bus.in_ready) begin
         chk("accept_timeout", 0, 1);
         bus.in_valid = 1'b0;
         return;
      end
      sat = (y < 0) || (y > 268435456);
      exp_q.push_back('{x: ref_x(y), sat: sat, lat: sat ? 1 : 17, accept: cyc + 1});
      sent++;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_y     = 33'($urandom);
   endtask

   // out_ready driven just after the active edge, away from the monitor's sample
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       bus.out_ready = ($urandom_range(0, 3) != 0);
         1:       bus.out_ready = 1'b1;
         default: bus.out_ready = 1'b0;
      endcase
   end

   // Monitor
   bit   prev_valid = 1'b0;
   exp_t cur;
   int   held_x;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (bus.out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", int'($signed(bus.out_x)), 99999999);
            end else begin
               cur = exp_q.pop_front();
               results++;
               held_x = int'($signed(bus.out_x));
               chk("out_x", held_x, cur.x);
               chk("latency", cyc - cur.accept, cur.lat);
`ifdef SIGINV_SAT_EN
               chk("out_sat", bus.out_sat, cur.sat);
`endif
            end
         end else if (bus.out_valid) begin
            chk("out_x_hold", int'($signed(bus.out_x)), held_x);
         end
         if (bus.out_valid) chk("in_ready_in_done", bus.in_ready, 0);
         prev_valid = bus.out_valid;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || !bus.in_ready) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk("idle_timeout", 0, 1);
   endtask

   longint directed[8] = '{134217728, 192937984, 192937985, 75497472,
                           268435456, 0, -5, 268435457};

   initial begin
      int n;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_y      = '0;
      bus.out_ready = 1'b1;
      #1;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_x", bus.out_x, 0);
`ifdef SIGINV_SAT_EN
      chk("rst_out_sat", bus.out_sat, 0);
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_rst", bus.in_ready, 1);

      // Directed values
      ready_mode = 1;
      foreach (directed[i]) begin
         send(directed[i]);
         wait_idle();
      end

      // Stall in DONE for 10 clocks, then release
      ready_mode = 2;
      send(192937984);
      n = 0;
      while (!bus.out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("stall_valid", bus.out_valid, 1);
      repeat (10) @(negedge clk);
      chk("stall_still_valid", bus.out_valid, 1);
      ready_mode = 1;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("stall_back_idle", bus.in_ready, 1);
      wait_idle();

      // Reset at CALC cycle 8 drops the result
      send(192937984);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_in_ready", bus.in_ready, 0);
      chk("midrst_out_x", bus.out_x, 0);
      void'(exp_q.pop_back());
      sent--;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_release_ready", bus.in_ready, 0);
      @(negedge clk);
      chk("midrst_ready_rise", bus.in_ready, 1);
      send(192937984);
      wait_idle();

      // Random sweep with gaps on both sides
      ready_mode = 0;
      for (int k = 0; k < 2000; k++) begin
         longint y;
         if ($urandom_range(0, 1) == 0)
            y = longint'($urandom_range(0, 32'h8000_0000)) - 64'sd1073741824;
         else
            y = longint'($urandom_range(0, 268435456));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         send(y);
      end
      ready_mode = 1;
      wait_idle();
      chk("result_count", results, sent);
      chk("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
